// File: rtl/depth_pkg.sv
// Shared constants and FSM encoding for the depthwise 3x3 window fetcher.
package depth_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int TAP_COUNT      = 9;
    localparam int COORD_W        = 7;
    localparam int FILT_W         = 6;
    localparam int TAP_IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;
endpackage

// File: rtl/depth_tap_gen.sv
// Maps a tap index around the window centre to a memory row/column and a padding flag.
module depth_tap_gen
    import depth_pkg::*;
(
    input  logic [TAP_IDX_W-1:0] Tap_Idx,
    input  logic [COORD_W-1:0]   Ctr_Row,
    input  logic [COORD_W-1:0]   Ctr_Col,
    input  logic [COORD_W-1:0]   Map_Last,
    output logic [COORD_W-1:0]   Tap_Row,
    output logic [COORD_W-1:0]   Tap_Col,
    output logic                 Tap_Pad
);
    logic signed [7:0] dr, dc, r, c, last_s;

    always_comb begin
        dr = 8'sd1;
        dc = 8'sd1;
        case (Tap_Idx)
            4'd0, 4'd1, 4'd2: dr = -8'sd1;
            4'd3, 4'd4, 4'd5: dr = 8'sd0;
            default:          dr = 8'sd1;
        endcase
        case (Tap_Idx)
            4'd0, 4'd3, 4'd6: dc = -8'sd1;
            4'd1, 4'd4, 4'd7: dc = 8'sd0;
            default:          dc = 8'sd1;
        endcase
        // 8-bit signed keeps -1 and 113 distinguishable from in-range indices
        r       = $signed({1'b0, Ctr_Row}) + dr;
        c       = $signed({1'b0, Ctr_Col}) + dc;
        last_s  = $signed({1'b0, Map_Last});
        Tap_Pad = (r < 0) || (r > last_s) || (c < 0) || (c > last_s);
        Tap_Row = r[COORD_W-1:0];
        Tap_Col = c[COORD_W-1:0];
    end
endmodule

// File: rtl/depth_window_fetch.sv
// Fetches a zero-padded 3x3 window from feature-map memory for the depthwise PE,
// one read per cycle with fixed latency regardless of padding.
module depth_window_fetch
    import depth_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       Coord_Valid,
    output logic                       Coord_Ready,
    input  logic [COORD_W-1:0]         Coord_Row,
    input  logic [COORD_W-1:0]         Coord_Col,
    input  logic [FILT_W-1:0]          Coord_Filter,
    input  logic [COORD_W-1:0]         Map_Last,
    input  logic                       Flush,
    output logic                       Mem_Rd_En,
    output logic [COORD_W-1:0]         Mem_Rd_Row,
    output logic [COORD_W-1:0]         Mem_Rd_Col,
    output logic [FILT_W-1:0]          Mem_Rd_Filter,
    input  logic [Data_Width-1:0]      Mem_Rd_Data,
    output logic                       Win_Valid,
    input  logic                       Win_Ready,
    output logic [9*Data_Width-1:0]    Win_Data,
    output logic [FILT_W-1:0]          Win_Filter
);
    state_t                  state_q, state_d;
    logic [TAP_IDX_W-1:0]    tap_idx_q, tap_idx_d;
    logic [COORD_W-1:0]      row_q, row_d, col_q, col_d, last_q, last_d;
    logic [FILT_W-1:0]       filt_q, filt_d;
    logic [9*Data_Width-1:0] win_q, win_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [TAP_IDX_W-1:0]    rd_tag_q, rd_tag_d;
    logic [COORD_W-1:0]      tap_row, tap_col;
    logic                    tap_pad;

    depth_tap_gen u_tap_gen (
        .Tap_Idx  (tap_idx_q),
        .Ctr_Row  (row_q),
        .Ctr_Col  (col_q),
        .Map_Last (last_q),
        .Tap_Row  (tap_row),
        .Tap_Col  (tap_col),
        .Tap_Pad  (tap_pad)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            tap_idx_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= '0;
            filt_q    <= '0;
            win_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            tap_idx_q <= tap_idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
            filt_q    <= filt_d;
            win_q     <= win_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tap_idx_d     = tap_idx_q;
        row_d         = row_q;
        col_d         = col_q;
        last_d        = last_q;
        filt_d        = filt_q;
        win_d         = win_q;
        rd_pend_d     = 1'b0;
        rd_tag_d      = rd_tag_q;
        Coord_Ready   = (state_q == ST_IDLE) && !Flush;
        Mem_Rd_En     = 1'b0;
        Mem_Rd_Row    = '0;
        Mem_Rd_Col    = '0;
        Mem_Rd_Filter = '0;
        Win_Valid     = (state_q == ST_OUT);

        // Data for last cycle's read lands in the tap recorded with it
        if (rd_pend_q)
            win_d[int'(rd_tag_q)*Data_Width +: Data_Width] = Mem_Rd_Data;

        case (state_q)
            ST_IDLE: begin
                if (Coord_Valid) begin
                    row_d     = Coord_Row;
                    col_d     = Coord_Col;
                    filt_d    = Coord_Filter;
                    last_d    = Map_Last;
                    win_d     = '0;
                    tap_idx_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!tap_pad) begin
                    Mem_Rd_En     = 1'b1;
                    Mem_Rd_Row    = tap_row;
                    Mem_Rd_Col    = tap_col;
                    Mem_Rd_Filter = filt_q;
                    rd_pend_d     = 1'b1;
                    rd_tag_d      = tap_idx_q;
                end
                if (tap_idx_q == TAP_IDX_W'(TAP_COUNT - 1))
                    state_d = ST_DRAIN;
                else
                    tap_idx_d = tap_idx_q + 1'b1;
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT: begin
                if (Win_Ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over accept and handshake; in-flight read data is dropped
        if (Flush) begin
            state_d   = ST_IDLE;
            tap_idx_d = '0;
            rd_pend_d = 1'b0;
            win_d     = win_q;
            row_d     = row_q;
            col_d     = col_q;
            filt_d    = filt_q;
            last_d    = last_q;
        end
    end

    assign Win_Data   = win_q;
    assign Win_Filter = filt_q;
endmodule

// File: tb/tb_depth_window_fetch.sv
// Directed bench with a memory model and scoreboards for reads and windows.
module tb_depth_window_fetch;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            RST;
    logic            Coord_Valid, Coord_Ready, Flush, Win_Ready;
    logic [6:0]      Coord_Row, Coord_Col, Map_Last;
    logic [5:0]      Coord_Filter;
    logic            Mem_Rd_En, Win_Valid;
    logic [6:0]      Mem_Rd_Row, Mem_Rd_Col;
    logic [5:0]      Mem_Rd_Filter, Win_Filter;
    logic [DW-1:0]   Mem_Rd_Data;
    logic [9*DW-1:0] Win_Data;

    typedef struct {
        logic [9*DW-1:0] data;
        logic [5:0]      filt;
    } win_t;
    typedef struct {
        logic [6:0] r;
        logic [6:0] c;
        logic [5:0] f;
    } rd_t;

    win_t wq[$];
    rd_t  rq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   waiting = 0;

    always #5 clk = ~clk;

    depth_window_fetch #(.Data_Width(DW)) dut (
        .clk(clk), .RST(RST),
        .Coord_Valid(Coord_Valid), .Coord_Ready(Coord_Ready),
        .Coord_Row(Coord_Row), .Coord_Col(Coord_Col), .Coord_Filter(Coord_Filter),
        .Map_Last(Map_Last), .Flush(Flush),
        .Mem_Rd_En(Mem_Rd_En), .Mem_Rd_Row(Mem_Rd_Row), .Mem_Rd_Col(Mem_Rd_Col),
        .Mem_Rd_Filter(Mem_Rd_Filter), .Mem_Rd_Data(Mem_Rd_Data),
        .Win_Valid(Win_Valid), .Win_Ready(Win_Ready),
        .Win_Data(Win_Data), .Win_Filter(Win_Filter)
    );

    function automatic logic [DW-1:0] mem_val(input int r, input int c, input int f);
        return DW'(r * 131 + c * 7 + f * 1009 + 1);
    endfunction

    // Memory answers one cycle after the strobe; junk otherwise
    always @(posedge clk)
        Mem_Rd_Data <= Mem_Rd_En ? mem_val(int'(Mem_Rd_Row), int'(Mem_Rd_Col), int'(Mem_Rd_Filter))
                                 : DW'($urandom);

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int r, input int c, input int f, input int last);
        win_t w;
        rd_t  e;
        w.data = '0;
        w.filt = 6'(f);
        for (int k = 0; k < 9; k++) begin
            int tr, tc;
            tr = r + k / 3 - 1;
            tc = c + k % 3 - 1;
            if (tr >= 0 && tr <= last && tc >= 0 && tc <= last) begin
                e.r = 7'(tr);
                e.c = 7'(tc);
                e.f = 6'(f);
                rq.push_back(e);
                w.data[k*DW +: DW] = mem_val(tr, tc, f);
            end
        end
        wq.push_back(w);
    endtask

    task automatic monitor();
        rd_t  e;
        win_t w;
        if (Coord_Valid && Coord_Ready && !Flush) begin
            push_expect(int'(Coord_Row), int'(Coord_Col), int'(Coord_Filter), int'(Map_Last));
            acc_cyc = cyc;
            waiting = 1;
        end
        if (Mem_Rd_En) begin
            if (rq.size() == 0) chk("rd_unexpected", Mem_Rd_En, 1'b0);
            else begin
                e = rq.pop_front();
                chk("rd_row", Mem_Rd_Row, e.r);
                chk("rd_col", Mem_Rd_Col, e.c);
                chk("rd_filter", Mem_Rd_Filter, e.f);
            end
        end
        if (Win_Valid && waiting) begin
            chk("latency", 160'(cyc - acc_cyc), 160'd11);
            waiting = 0;
        end
        if (Win_Valid && Win_Ready && !Flush) begin
            if (wq.size() == 0) chk("win_unexpected", Win_Valid, 1'b0);
            else begin
                w = wq.pop_front();
                chk("win_data", Win_Data, w.data);
                chk("win_filter", Win_Filter, w.filt);
            end
        end
    endtask

    task automatic cycle();
        #1 monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input int r, input int c, input int f);
        Coord_Valid  = 1'b1;
        Coord_Row    = 7'(r);
        Coord_Col    = 7'(c);
        Coord_Filter = 6'(f);
        #1 chk("accept_ready", Coord_Ready, 1'b1);
        cycle();
        Coord_Valid = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while (wq.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (wq.size() != 0) chk("timeout", 160'(wq.size()), 160'd0);
        chk("reads_left", 160'(rq.size()), 160'd0);
    endtask

    initial begin
        RST = 1'b0; Coord_Valid = 1'b0; Flush = 1'b0; Win_Ready = 1'b1;
        Coord_Row = '0; Coord_Col = '0; Coord_Filter = '0; Map_Last = 7'd111;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", Mem_Rd_En, 1'b0);
        chk("rst_rd_addr", {Mem_Rd_Row, Mem_Rd_Col, Mem_Rd_Filter}, '0);
        chk("rst_win_valid", Win_Valid, 1'b0);
        chk("rst_win_data", Win_Data, '0);
        chk("rst_win_filter", Win_Filter, '0);
        RST = 1'b1;
        #1 chk("rst_ready", Coord_Ready, 1'b1);
        @(negedge clk);

        send(5, 5, 3);       run_done(40);
        send(0, 0, 7);       run_done(40);
        send(111, 111, 36);  run_done(40);

        // Back-pressure: window held while consumer stalls, next coordinate waits
        Win_Ready = 1'b0;
        send(10, 20, 5);
        repeat (10) cycle();
        Coord_Valid = 1'b1; Coord_Row = 7'd30; Coord_Col = 7'd40; Coord_Filter = 6'd1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hold_valid", Win_Valid, 1'b1);
            chk("hold_ready", Coord_Ready, 1'b0);
            if (wq.size() > 0) chk("hold_data", Win_Data, wq[0].data);
            cycle();
        end
        Win_Ready = 1'b1;
        cycle();
        #1 chk("ready_after_out", Coord_Ready, 1'b1);
        cycle();
        Coord_Valid = 1'b0;
        run_done(40);

        // Flush while issuing tap 4
        send(50, 60, 9);
        repeat (4) cycle();
        Flush = 1'b1;
        cycle();
        Flush = 1'b0;
        wq.delete(); rq.delete(); waiting = 0;
        #1 chk("flush_idle", Coord_Ready, 1'b1);
        repeat (15) cycle();
        send(2, 2, 12);      run_done(40);

        // Reset during DRAIN
        send(7, 8, 2);
        repeat (9) cycle();
        RST = 1'b0;
        #1;
        chk("mid_rst_rd_en", Mem_Rd_En, 1'b0);
        chk("mid_rst_addr", {Mem_Rd_Row, Mem_Rd_Col, Mem_Rd_Filter}, '0);
        chk("mid_rst_valid", Win_Valid, 1'b0);
        chk("mid_rst_data", Win_Data, '0);
        chk("mid_rst_filter", Win_Filter, '0);
        wq.delete(); rq.delete(); waiting = 0;
        @(negedge clk);
        RST = 1'b1;
        repeat (5) cycle();
        Map_Last = 7'd100;
        send(9, 100, 20);    run_done(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/depth_window_fetch.md
DEPTH_WINDOW_FETCH -- requirements
Module: depth_window_fetch

Interface
REQ-001 Parameter: Data_Width, default 16, pixel width in bits.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Coord_Valid  input  1  read coordinate from depth controller is valid.
REQ-005 Coord_Ready  output  1  block accepts a coordinate this cycle.
REQ-006 Coord_Row  input  7  window-centre row (0..112).
REQ-007 Coord_Col  input  7  window-centre column (0..112).
REQ-008 Coord_Filter  input  6  channel index (0..36).
REQ-009 Map_Last  input  7  last valid row/column index of the feature map (square map); sampled at accept.
REQ-010 Flush  input  1  synchronous abort of the current window.
REQ-011 Mem_Rd_En  output  1  feature-map memory read strobe.
REQ-012 Mem_Rd_Row, Mem_Rd_Col  output  7 each  read address row/column.
REQ-013 Mem_Rd_Filter  output  6  read address channel.
REQ-014 Mem_Rd_Data  input  Data_Width  read data, valid exactly 1 cycle after Mem_Rd_En.
REQ-015 Win_Valid  output  1  3x3 window available.
REQ-016 Win_Ready  input  1  consumer (depthwise PE) takes the window.
REQ-017 Win_Data  output  9*Data_Width  window; tap k at bits [k*Data_Width +: Data_Width].
REQ-018 Win_Filter  output  6  channel of the presented window.

Function
REQ-019 Tap k = 3*(dr+1)+(dc+1), dr,dc in {-1,0,+1}; tap 0 = top-left, tap 4 = centre, tap 8 = bottom-right.
REQ-020 FSM states: IDLE, ISSUE, DRAIN, OUT; reset state IDLE.
REQ-021 Coord_Ready = 1 only in IDLE; accept = Coord_Valid && Coord_Ready; on accept, latch row, col, filter and Map_Last, clear all tap registers to 0, go to ISSUE with tap index 0.
REQ-022 ISSUE: one tap per cycle, taps 0..8 in order; after tap 8, go to DRAIN.
REQ-023 Tap row = latched row + dr, tap col = latched col + dc, both computed 8-bit signed; tap is padded if either value < 0 or > Map_Last.
REQ-024 Non-padded tap: Mem_Rd_En=1 with tap address and latched filter; padded tap: Mem_Rd_En=0, address outputs hold 0, tap register stays 0.
REQ-025 Mem_Rd_Data captured into the tap register of the read issued the previous cycle (1-deep tag pipeline).
REQ-026 DRAIN lasts exactly 1 cycle (captures tap 8), then OUT.
REQ-027 Fixed latency: accept in cycle N -> Win_Valid first high in cycle N+11, independent of padding.
REQ-028 OUT: Win_Valid=1; Win_Data and Win_Filter stable until Win_Valid && Win_Ready; then IDLE next cycle (Win_Valid low).
REQ-029 Throughput: one window per 12 cycles minimum; Coord_Valid held high while not ready is not lost.
REQ-030 Flush in any state: next cycle IDLE, Win_Valid=0, Mem_Rd_En=0; read data returning after Flush is discarded; Flush overrides a simultaneous accept or Win_Ready.
REQ-031 Centre outside 0..Map_Last is legal; all taps evaluated per REQ-023 (all-padded gives zero window).
REQ-032 Mem_Rd_En is never high outside ISSUE.

Reset
REQ-033 RST low asynchronously forces: state IDLE, Coord_Ready=1 after release, Mem_Rd_En=0, Mem_Rd_Row/Col/Filter=0, Win_Valid=0, Win_Data=0, Win_Filter=0, tap index=0.
REQ-034 Reset mid-window discards the window; no read strobe after reset until a new accept.

Structure
REQ-035 Shared package depth_pkg holds: Data_Width default, tap count 9, FSM state encoding, coordinate widths (7 row/col, 6 filter).
REQ-036 Sub-module depth_tap_gen: combinational; tap index, centre, Map_Last in -> tap row/col and pad flag out.

Verification
REQ-037 Centre (5,5,filter 3), Map_Last 111, Win_Ready=1 -> 9 reads (4..6 x 4..6, filter 3) in raster order, Win_Valid 11 cycles after accept, taps match memory.
REQ-038 Centre (0,0), Map_Last 111 -> only taps 4,5,7,8 read; taps 0,1,2,3,6 = 0; latency still 11.
REQ-039 Centre (111,111), Map_Last 111 -> taps 2,5,6,7,8 = 0; no address 112 ever driven.
REQ-040 Win_Ready low for 20 cycles in OUT -> Win_Valid and Win_Data held, Coord_Ready=0; Win_Ready high -> IDLE next cycle, next coordinate accepted.
REQ-041 Flush asserted in ISSUE at tap 4 -> next cycle IDLE, Win_Valid never rises, following window (2,2) fetched correctly.
REQ-042 RST pulsed low during DRAIN -> all outputs 0 immediately; after release, new accept yields correct window.
